mul8u_share_arb: RTL and testbench
==================================

# mul8u_share_arb

Round-robin arbiter and pipeline sequencer that lets NREQ requesters share a single combinational 8x8 unsigned approximate multiplier core. The core itself sits outside the block, connected through the mul_a/mul_b/mul_o ports, so any multiplier variant in the library can be plugged in without changing this block. The block registers operands and results around the core, returning a 2-cycle, fully backpressured, ID-tagged result stream, and counts completed operations.

## Interface
- NREQ, 4: number of requesters, 2..8
- IDW, 2: width of resp_id, equal to clog2(NREQ)
- clk  in  1  clock, all state updates on the rising edge
- rst_n  in  1  synchronous active-low reset
- req_valid  in  NREQ  request valid, one bit per requester
- req_a  in  8*NREQ  operand A; requester i uses bits [8i+7:8i]
- req_b  in  8*NREQ  operand B, same packing as req_a
- req_ready  out  NREQ  one-hot or zero; the request is accepted when req_valid[i] & req_ready[i]
- mul_a  out  8  operand A to the external multiplier, driven directly from the operand register
- mul_b  out  8  operand B to the external multiplier
- mul_o  in  16  combinational product returned from the external multiplier
- resp_valid  out  1  result valid
- resp_data  out  16  product, captured from mul_o
- resp_id  out  IDW  index of the requester that issued the operation
- resp_ready  in  1  downstream accepts the result
- op_count  out  16  number of completed responses, wraps at 16 bits

## Operation
- **Pipeline.** Two stages.
  - Stage S1 holds operands: s1_valid, s1_a, s1_b, s1_id.
  - Stage S2 holds the result: s2_valid, s2_data, s2_id.
  - resp_valid, resp_data and resp_id are driven from S2.
  - mul_a and mul_b equal s1_a and s1_b.
- **Stage advance.**
  - adv2 = s1_valid & (~s2_valid | resp_ready). When adv2 is high, S2 loads mul_o and s1_id on the clock edge.
  - S1 can accept a new operation when acc1 = ~s1_valid | adv2.
- **Arbitration.**
  - The grant is combinational and round-robin. It goes to the first i with req_valid[i] high, searching from pointer rr upward and wrapping past NREQ-1 to 0.
  - req_ready[i] = grant[i] & acc1.
  - req_ready never asserts for a requester whose req_valid is low, and never asserts while acc1 is low.
- **Pointer update.** On each accepted request from requester g, rr becomes (g+1) mod NREQ. With no acceptance, rr is unchanged.
- **Drain.** When S2 is valid, resp_ready is high and adv2 is low, s2_valid clears.
- **Counter.** op_count increments by 1 on every resp_valid & resp_ready. It wraps from 0xFFFF to 0x0000.
- **Data integrity.**
  - S1 contents are held while s1_valid is high and adv2 is low.
  - S2 contents are held while resp_valid is high and resp_ready is low.
  - The multiplier is never fed changing operands while its result is pending.
- **Reset.**
  - rst_n low on a clock edge clears s1_valid, s2_valid, rr and op_count.
  - Any in-flight operations are discarded and no response is produced for them.
  - During reset, req_ready, resp_valid and op_count read 0.
  - Data registers need not be reset.

## Timing
- Latency is 2 cycles. A request accepted at edge t has its operands in S1 after t and appears on resp_valid after edge t+1.
- Throughput is one operation per cycle while resp_ready is held high.
- All requests arriving in the same cycle resolve through the round-robin grant; exactly one is accepted per cycle.
- When resp_ready is low with S1 and S2 both full, req_ready is all zero. The first cycle resp_ready rises, S2 drains, S1 advances, and a new request is accepted in that same cycle with no bubble.
- A requester that holds req_valid waits at most NREQ-1 acceptances of other requesters.
- The mul_o path is combinational between the S1 and S2 registers, so the core's delay must fit within one clock period.

## Structure
- A shared package holds the constants and typedefs:
  - MUL_W = 8 and PROD_W = 16.
  - Typedef op_t: {a, b, id}.
  - Typedef res_t: {data, id}.
- One natural sub-module: **rr_arb**, a parameterised NREQ-way round-robin grant with pointer input. It is combinational; its pointer register lives in the parent.
- The multiplier core is not instantiated here. The integration wrapper connects it to mul_a, mul_b and mul_o.

## Test plan
Benches use an exact multiplier on mul_o for checking; a separate smoke run uses an approximate core.
- **Single request.** Requester 2 sends a=0xFF, b=0xFF with resp_ready=1 → resp_valid exactly 2 cycles after acceptance, resp_data=0xFE01, resp_id=2, op_count=1.
- **All four requesting.** All four hold valid with a=i+1, b=0x10 → accept order 0,1,2,3,0…; one response per cycle with data 0x10,0x20,0x30,0x40.
- **Backpressure.** resp_ready=0 for 5 cycles with continuous requests → after 2 acceptances req_ready is all zero. resp_data stays stable. On release, no result is lost or duplicated and the ID sequence stays in order.
- **Fairness.** Requester 0 requests continuously while requester 3 asserts once → requester 3 is accepted within 1 acceptance of requester 0.
- **Reset mid-operation.** rst_n low for 1 cycle with S1 and S2 both full → resp_valid=0 and op_count=0 next cycle, no stale response afterwards, rr=0 so requester 0 wins the first tie.
- **Counter wrap.** Preload via 65536 completed responses → op_count=0x0000.

Source files
------------

// File: rtl/mul8u_share_arb_pkg.sv
// Shared constants and operand/result records for the shared 8x8 multiplier sequencer.
// ID fields are sized for the largest supported requester count (8).
package mul8u_share_arb_pkg;

    localparam int MUL_W    = 8;
    localparam int PROD_W   = 16;
    localparam int ID_MAX_W = 3;

    typedef struct packed {
        logic [MUL_W-1:0]    a;
        logic [MUL_W-1:0]    b;
        logic [ID_MAX_W-1:0] id;
    } op_t;

    typedef struct packed {
        logic [PROD_W-1:0]   data;
        logic [ID_MAX_W-1:0] id;
    } res_t;

    // Round-robin successor of a granted index.
    function automatic int rr_next(input int g, input int n);
        return (g + 1) % n;
    endfunction

endpackage

// File: rtl/mul8u_share_arb_rr_arb.sv
// NREQ-way round-robin grant: first asserted request at or above ptr, wrapping to 0.
// Purely combinational (0 cycles); the pointer register lives in the parent.
// No backpressure of its own; the parent qualifies the grant with its accept condition.
module mul8u_share_arb_rr_arb
    import mul8u_share_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  grant_id,
    output logic            any
);

    logic [IDW-1:0] idx;

    always_comb begin
        grant    = '0;
        grant_id = '0;
        any      = 1'b0;
        idx      = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = IDW'((int'(ptr) + k) % NREQ);
            if (!any && req[idx]) begin
                any         = 1'b1;
                grant[idx]  = 1'b1;
                grant_id    = idx;
            end
        end
    end

endmodule

// File: rtl/mul8u_share_arb.sv
// Round-robin sharing of one external combinational 8x8 multiplier among NREQ requesters.
// Latency 2 cycles (operand register S1, result register S2), one op/cycle sustained.
// Fully backpressured: S2 holds under resp_ready low, S1 then holds, then req_ready drops to zero.
module mul8u_share_arb
    import mul8u_share_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [8*NREQ-1:0]     req_a,
    input  logic [8*NREQ-1:0]     req_b,
    output logic [NREQ-1:0]       req_ready,
    output logic [7:0]            mul_a,
    output logic [7:0]            mul_b,
    input  logic [15:0]           mul_o,
    output logic                  resp_valid,
    output logic [15:0]           resp_data,
    output logic [IDW-1:0]        resp_id,
    input  logic                  resp_ready,
    output logic [15:0]           op_count
);

    logic            s1_valid;
    op_t             s1;
    logic            s2_valid;
    res_t            s2;
    logic [IDW-1:0]  rr;
    logic [15:0]     cnt;

    logic [NREQ-1:0] grant;
    logic [IDW-1:0]  gnt_id;
    logic            gnt_any;
    logic            adv2;
    logic            acc1;
    logic            accept;
    logic            unused_id_hi;

    mul8u_share_arb_rr_arb #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_rr_arb (
        .req      (req_valid),
        .ptr      (rr),
        .grant    (grant),
        .grant_id (gnt_id),
        .any      (gnt_any)
    );

    assign adv2   = s1_valid & (~s2_valid | resp_ready);
    assign acc1   = ~s1_valid | adv2;
    // rst_n gating keeps the handshake outputs quiet while reset is held.
    assign accept = gnt_any & acc1 & rst_n;

    assign req_ready  = grant & {NREQ{acc1 & rst_n}};
    assign mul_a      = s1.a;
    assign mul_b      = s1.b;
    assign resp_valid = s2_valid & rst_n;
    assign resp_data  = s2.data;
    assign resp_id    = s2.id[IDW-1:0];
    assign op_count   = rst_n ? cnt : 16'h0000;

    assign unused_id_hi = ^s2.id;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            rr       <= '0;
            cnt      <= 16'h0000;
        end else begin
            if (accept) begin
                s1_valid <= 1'b1;
            end else if (adv2) begin
                s1_valid <= 1'b0;
            end

            if (adv2) begin
                s2_valid <= 1'b1;
            end else if (resp_ready) begin
                s2_valid <= 1'b0;
            end

            if (accept) begin
                rr <= IDW'(rr_next(int'(gnt_id), NREQ));
            end

            if (s2_valid && resp_ready) begin
                cnt <= cnt + 16'd1;
            end
        end
    end

    // Data registers carry no reset; their valid bits qualify them.
    always_ff @(posedge clk) begin
        if (accept) begin
            s1.a  <= req_a[int'(gnt_id)*MUL_W +: MUL_W];
            s1.b  <= req_b[int'(gnt_id)*MUL_W +: MUL_W];
            s1.id <= ID_MAX_W'(gnt_id);
        end
        if (adv2) begin
            s2.data <= mul_o;
            s2.id   <= s1.id;
        end
    end

endmodule

// File: tb/tb_mul8u_share_arb.sv
// Bench for mul8u_share_arb: exact multiplier on mul_o, queue-based reference model.
module tb_mul8u_share_arb;

    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   req_valid = '0;
    logic [8*N-1:0] req_a = '0;
    logic [8*N-1:0] req_b = '0;
    logic [N-1:0]   req_ready;
    logic [7:0]     mul_a, mul_b;
    logic [15:0]    mul_o;
    logic           resp_valid;
    logic [15:0]    resp_data;
    logic [1:0]     resp_id;
    logic           resp_ready = 1'b1;
    logic [15:0]    op_count;

    always #5 clk = ~clk;

    assign mul_o = {8'h00, mul_a} * {8'h00, mul_b};

    mul8u_share_arb #(.NREQ(N), .IDW(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_ready  (req_ready),
        .mul_a      (mul_a),
        .mul_b      (mul_b),
        .mul_o      (mul_o),
        .resp_valid (resp_valid),
        .resp_data  (resp_data),
        .resp_id    (resp_id),
        .resp_ready (resp_ready),
        .op_count   (op_count)
    );

    // Reference model: ordered list of in-flight ops; 'shown' means the oldest is presented.
    typedef struct {
        logic [15:0] prod;
        int          id;
    } op_s;

    op_s         pend[$];
    bit          shown = 1'b0;
    int          m_rr = 0;
    logic [15:0] m_cnt = 16'h0;
    int          total = 0;
    int          bad = 0;
    logic [N-1:0] exp_rdy;
    int          exp_g;
    logic [38:0] exp_v, got_v;

    task automatic sample();
        logic        v;
        logic [15:0] d;
        logic [1:0]  id;
        int          in_flight_waiting;
        @(negedge clk);
        exp_rdy = '0;
        exp_g   = -1;
        v = 1'b0; d = 16'h0; id = 2'd0;
        if (rst_n) begin
            for (int k = 0; k < N; k++) begin
                int i;
                i = (m_rr + k) % N;
                if (exp_g < 0 && req_valid[i]) exp_g = i;
            end
            in_flight_waiting = pend.size() - (shown ? 1 : 0);
            if (exp_g >= 0 && (in_flight_waiting == 0 || !shown || resp_ready))
                exp_rdy[exp_g] = 1'b1;
            if (shown) begin
                v  = 1'b1;
                d  = pend[0].prod;
                id = 2'(pend[0].id);
            end
        end
        exp_v = {exp_rdy, v, d, id, rst_n ? m_cnt : 16'h0};
        got_v = {req_ready, resp_valid, resp_valid ? resp_data : 16'h0,
                 resp_valid ? resp_id : 2'd0, op_count};
    endtask

    task automatic edge_step();
        op_s o;
        if (!rst_n) begin
            pend.delete();
            shown = 1'b0;
            m_rr  = 0;
            m_cnt = 16'h0;
        end else begin
            if (shown && resp_ready) begin
                void'(pend.pop_front());
                m_cnt = m_cnt + 16'd1;
                shown = 1'b0;
            end
            if (!shown && pend.size() > 0) shown = 1'b1;
            if (exp_rdy != '0) begin
                o.prod = {8'h00, req_a[8*exp_g +: 8]} * {8'h00, req_b[8*exp_g +: 8]};
                o.id   = exp_g;
                pend.push_back(o);
                m_rr = (exp_g + 1) % N;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        sample();
        edge_step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req_valid = '1;
        resp_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            sample();
            total++;
            if (got_v !== exp_v) begin
                bad++;
                $display("FAIL reset c=%0d got=%h exp=%h", c, got_v, exp_v);
            end
            edge_step();
        end
        rst_n = 1'b1;
        req_valid = '0;
    endtask

    task automatic test_single();
        int acc_c = -1;
        int vld_c = -1;
        req_a[8*2 +: 8] = 8'hFF;
        req_b[8*2 +: 8] = 8'hFF;
        req_valid = 4'b0100;
        resp_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            sample();
            total++;
            if (got_v !== exp_v) begin
                bad++;
                $display("FAIL single c=%0d got=%h exp=%h", c, got_v, exp_v);
            end
            if (req_ready[2] && acc_c < 0) acc_c = c;
            if (resp_valid && vld_c < 0) begin
                vld_c = c;
                total++;
                if (resp_data !== 16'hFE01 || resp_id !== 2'd2) begin
                    bad++;
                    $display("FAIL single_data got=%h/%0d exp=fe01/2", resp_data, resp_id);
                end
            end
            edge_step();
            if (acc_c >= 0) req_valid = '0;
        end
        total++;
        if (vld_c - acc_c !== 2) begin
            bad++;
            $display("FAIL single_latency got=%0d exp=2", vld_c - acc_c);
        end
        sample();
        total++;
        if (op_count !== 16'd1) begin
            bad++;
            $display("FAIL single_count got=%0d exp=1", op_count);
        end
        edge_step();
    endtask

    task automatic test_all_four();
        for (int i = 0; i < N; i++) begin
            req_a[8*i +: 8] = 8'(i + 1);
            req_b[8*i +: 8] = 8'h10;
        end
        req_valid = '1;
        resp_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            sample();
            total++;
            if (got_v !== exp_v) begin
                bad++;
                $display("FAIL all_four c=%0d got=%h exp=%h", c, got_v, exp_v);
            end
            edge_step();
        end
        req_valid = '0;
    endtask

    task automatic test_backpressure();
        int acc = 0;
        bit held_set = 1'b0;
        logic [15:0] held = 16'h0;
        req_valid = '0;
        resp_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            sample();
            edge_step();
        end
        resp_ready = 1'b0;
        req_valid = '1;
        for (int c = 0; c < 5; c++) begin
            req_a = $urandom();
            req_b = $urandom();
            sample();
            total++;
            if (got_v !== exp_v) begin
                bad++;
                $display("FAIL bp_hold c=%0d got=%h exp=%h", c, got_v, exp_v);
            end
            if ((req_ready & req_valid) != '0) acc++;
            if (resp_valid) begin
                if (held_set) begin
                    total++;
                    if (resp_data !== held) begin
                        bad++;
                        $display("FAIL bp_stable got=%h exp=%h", resp_data, held);
                    end
                end
                held = resp_data;
                held_set = 1'b1;
            end
            edge_step();
        end
        total++;
        if (acc !== 2) begin
            bad++;
            $display("FAIL bp_accepts got=%0d exp=2", acc);
        end
        resp_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            if (c == 6) req_valid = '0;
            sample();
            total++;
            if (got_v !== exp_v) begin
                bad++;
                $display("FAIL bp_release c=%0d got=%h exp=%h", c, got_v, exp_v);
            end
            edge_step();
        end
    endtask

    task automatic test_fairness();
        bit got3 = 1'b0;
        int n0 = 0;
        resp_ready = 1'b1;
        req_valid = 4'b0001;
        for (int c = 0; c < 3; c++) begin
            sample();
            edge_step();
        end
        req_valid = 4'b1001;
        for (int c = 0; c < 8 && !got3; c++) begin
            sample();
            total++;
            if (got_v !== exp_v) begin
                bad++;
                $display("FAIL fair c=%0d got=%h exp=%h", c, got_v, exp_v);
            end
            if (req_ready[3]) got3 = 1'b1;
            else if (req_ready[0]) n0++;
            edge_step();
        end
        req_valid = '0;
        total++;
        if (!got3 || n0 > 1) begin
            bad++;
            $display("FAIL fair_wait got3=%0d req0_before=%0d exp<=1", got3, n0);
        end
    endtask

    task automatic test_reset_mid();
        resp_ready = 1'b0;
        req_valid = '1;
        for (int c = 0; c < 3; c++) begin
            req_a = $urandom();
            req_b = $urandom();
            sample();
            edge_step();
        end
        rst_n = 1'b0;
        sample();
        total++;
        if (got_v !== exp_v) begin
            bad++;
            $display("FAIL rst_mid_hold got=%h exp=%h", got_v, exp_v);
        end
        edge_step();
        rst_n = 1'b1;
        resp_ready = 1'b1;
        sample();
        total++;
        if (req_ready !== 4'b0001 || resp_valid !== 1'b0 || op_count !== 16'h0) begin
            bad++;
            $display("FAIL rst_mid_after got rdy=%b vld=%b cnt=%0d exp rdy=0001 vld=0 cnt=0",
                     req_ready, resp_valid, op_count);
        end
        edge_step();
        req_valid = '0;
        for (int c = 0; c < 6; c++) begin
            sample();
            total++;
            if (got_v !== exp_v) begin
                bad++;
                $display("FAIL rst_mid_run c=%0d got=%h exp=%h", c, got_v, exp_v);
            end
            edge_step();
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            req_valid  = N'($urandom());
            req_a      = $urandom();
            req_b      = $urandom();
            resp_ready = ($urandom_range(0, 3) != 0);
            sample();
            total++;
            if (got_v !== exp_v) begin
                bad++;
                $display("FAIL random c=%0d got=%h exp=%h", c, got_v, exp_v);
            end
            edge_step();
        end
        req_valid = '0;
        resp_ready = 1'b1;
    endtask

    task automatic test_wrap();
        int done = 0;
        int guard = 0;
        do_reset();
        req_valid = 4'b0001;
        req_a[7:0] = 8'h03;
        req_b[7:0] = 8'h05;
        resp_ready = 1'b1;
        while (done < 65536 && guard < 70000) begin
            sample();
            total++;
            if (got_v !== exp_v) begin
                bad++;
                $display("FAIL wrap_run c=%0d got=%h exp=%h", guard, got_v, exp_v);
            end
            if (resp_valid && resp_ready) done++;
            edge_step();
            guard++;
        end
        req_valid = '0;
        sample();
        total++;
        if (done !== 65536 || op_count !== 16'h0000) begin
            bad++;
            $display("FAIL wrap done=%0d op_count=%h exp done=65536 op_count=0000", done, op_count);
        end
        edge_step();
    endtask

    initial begin
        test_reset();
        test_single();
        test_all_four();
        test_backpressure();
        test_fairness();
        test_reset_mid();
        test_random();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
